// File: rtl/fpga_receiver.sv
// fpga_receiver: serial link receiver, one bit per
// four-phase handshake, word closed by a finish handshake.
module fpga_receiver #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dataIn,
  input  logic             sendToOther,
  input  logic             finish,
  input  logic             read,
  output logic             acknowledge,
  output logic [WIDTH-1:0] dataOut,
  output logic             byteReady,
  output logic             overrun,
  output logic             frameError
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    BIT_ACK,
    FIN
  } state_t;

  state_t state, nextState;

  logic [SYNC_STAGES-1:0] dSync, rSync, fSync;
  logic dataS, reqS, finS;

  logic [WIDTH-1:0] sh;
  logic [CW-1:0]    cnt;

  logic capture, close, full;

  // synchronize the asynchronous link inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      dSync <= '0;
      rSync <= '0;
      fSync <= '0;
    end else begin
      dSync <= {dSync[SYNC_STAGES-2:0], dataIn};
      rSync <= {rSync[SYNC_STAGES-2:0], sendToOther};
      fSync <= {fSync[SYNC_STAGES-2:0], finish};
    end
  end

  assign dataS = dSync[SYNC_STAGES-1];
  assign reqS  = rSync[SYNC_STAGES-1];
  assign finS  = fSync[SYNC_STAGES-1];

  assign full    = (cnt == FULL);
  assign close   = (state == IDLE) && finS;
  assign capture = (state == IDLE) && !finS && reqS
                 && (cnt < FULL);

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // next-state logic; finish wins over a bit request
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (finS)         nextState = FIN;
        else if (capture) nextState = BIT_ACK;
      end
      BIT_ACK: if (!reqS) nextState = IDLE;
      FIN:     if (!finS) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // handshake reply is a pure decode of the state register
  always_comb begin
    acknowledge = (state != IDLE);
  end

  // shift register and bit counter
  always_ff @(posedge clk) begin
    if (reset) begin
      sh  <= '0;
      cnt <= '0;
    end else if (capture) begin
      sh  <= {sh[WIDTH-2:0], dataS};
      cnt <= cnt + 1'b1;
    end else if (close) begin
      cnt <= '0;
    end
  end

  // word delivery, ready flag and error pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      dataOut    <= '0;
      byteReady  <= 1'b0;
      overrun    <= 1'b0;
      frameError <= 1'b0;
    end else begin
      overrun    <= close && full && byteReady && !read;
      frameError <= close && !full;
      if (close && full) begin
        dataOut   <= sh;
        byteReady <= 1'b1;
      end else if (read) begin
        byteReady <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fpga_receiver.sv
// tb_fpga_receiver: drives the remote side of the link and
// checks against a transaction-level model of the receiver.
module tb_fpga_receiver;

  localparam int WIDTH = 8;
  localparam int LAT   = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             dataIn;
  logic             sendToOther;
  logic             finish;
  logic             read;
  logic             acknowledge;
  logic [WIDTH-1:0] dataOut;
  logic             byteReady;
  logic             overrun;
  logic             frameError;

  int vectors = 0;
  int errors  = 0;

  bit         q[$];
  logic [7:0] mData  = '0;
  bit         mReady = 1'b0;

  fpga_receiver #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .dataIn      (dataIn),
    .sendToOther (sendToOther),
    .finish      (finish),
    .read        (read),
    .acknowledge (acknowledge),
    .dataOut     (dataOut),
    .byteReady   (byteReady),
    .overrun     (overrun),
    .frameError  (frameError)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic doBit(input bit b);
    bit expAck;
    int lat;
    int seen;
    expAck = (q.size() < WIDTH);
    @(negedge clk) dataIn = b;
    @(negedge clk) sendToOther = 1'b1;
    if (expAck) begin
      lat = 99;
      for (int i = 1; i <= 10; i++) begin
        @(negedge clk);
        if (acknowledge) begin
          lat = i;
          break;
        end
      end
      check("ackRise", lat, LAT);
      sendToOther = 1'b0;
      lat = 99;
      for (int i = 1; i <= 10; i++) begin
        @(negedge clk);
        if (!acknowledge) begin
          lat = i;
          break;
        end
      end
      check("ackFall", lat, LAT);
      q.push_back(b);
    end else begin
      seen = 0;
      repeat (8) begin
        @(negedge clk);
        if (acknowledge) seen++;
      end
      check("ignoredAck", seen, 0);
      sendToOther = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic sendBits(input logic [8:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) doBit(v[i]);
  endtask

  task automatic doFinish(input bit rd);
    bit         isFull;
    bit         expOv;
    logic [7:0] w;
    int         lat;
    int         ovCnt;
    int         feCnt;
    isFull = (q.size() == WIDTH);
    w = '0;
    foreach (q[i]) w = {w[6:0], q[i]};
    expOv = isFull && mReady && !rd;
    if (isFull) begin
      mData  = w;
      mReady = 1'b1;
    end else if (rd) begin
      mReady = 1'b0;
    end
    q.delete();
    ovCnt = 0;
    feCnt = 0;
    lat = 99;
    @(negedge clk) finish = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      ovCnt += int'(overrun);
      feCnt += int'(frameError);
      read = (rd && i == 2);
      if (acknowledge) begin
        lat = i;
        break;
      end
    end
    read = 1'b0;
    check("finAck", lat, LAT);
    check("dataOut", dataOut, mData);
    check("byteReady", byteReady, mReady);
    finish = 1'b0;
    lat = 99;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      ovCnt += int'(overrun);
      feCnt += int'(frameError);
      if (!acknowledge) begin
        lat = i;
        break;
      end
    end
    check("finFall", lat, LAT);
    check("overrunPulses", ovCnt, int'(expOv));
    check("frameErrPulses", feCnt, int'(!isFull));
  endtask

  task automatic pulseRead();
    @(negedge clk) read = 1'b1;
    @(negedge clk) read = 1'b0;
    mReady = 1'b0;
    check("readClears", byteReady, 1'b0);
    check("readHolds", dataOut, mData);
  endtask

  function automatic logic [11:0] outs();
    return {acknowledge, byteReady, overrun,
            frameError, dataOut};
  endfunction

  initial begin
    reset       = 1'b1;
    dataIn      = 1'b0;
    sendToOther = 1'b0;
    finish      = 1'b0;
    read        = 1'b0;
    repeat (3) @(negedge clk);
    check("resetOuts", outs(), 12'h000);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    sendBits(9'h0A5, 8);
    doFinish(1'b0);
    pulseRead();

    sendBits(9'h03C, 8);
    doFinish(1'b0);
    sendBits(9'h0C3, 8);
    doFinish(1'b0);
    pulseRead();

    sendBits(9'h03C, 8);
    doFinish(1'b0);
    pulseRead();
    sendBits(9'h0C3, 8);
    doFinish(1'b0);

    sendBits(9'h015, 5);
    doFinish(1'b0);
    pulseRead();
    sendBits(9'h0FF, 8);
    doFinish(1'b0);

    sendBits(9'h0B5, 9);
    doFinish(1'b0);

    sendBits(9'h00F, 4);
    @(negedge clk) dataIn = 1'b1;
    @(negedge clk) sendToOther = 1'b1;
    for (int i = 0; i < 10 && !acknowledge; i++)
      @(negedge clk);
    check("preResetAck", acknowledge, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("duringReset", outs(), 12'h000);
    sendToOther = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    q.delete();
    mData  = '0;
    mReady = 1'b0;
    @(negedge clk);
    check("afterReset", outs(), 12'h000);
    sendBits(9'h081, 8);
    doFinish(1'b0);

    sendBits(9'h066, 8);
    doFinish(1'b1);
    pulseRead();
    pulseRead();

    for (int k = 0; k < 8; k++) begin
      int  n;
      bit  rd;
      logic [8:0] v;
      v  = 9'($urandom);
      n  = ($urandom_range(0, 3) == 0)
         ? int'($urandom_range(1, 9)) : 8;
      rd = 1'($urandom_range(0, 1));
      sendBits(v, n);
      doFinish(rd);
      if ($urandom_range(0, 1) == 1) pulseRead();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
